// File: rtl/parking_pkg.sv
// Shared types, defaults and helpers for the parking slot sensor front-end.
// Contents:
//   slot_state_t  per-slot debounce FSM state (FREE, ARRIVING, OCCUPIED, LEAVING)
//   DEF_*         default values for the top-level parameters
//   popcount      number of set bits in a vector of up to 32 bits
package parking_pkg;

  typedef enum logic [1:0] {
    FREE     = 2'd0,
    ARRIVING = 2'd1,
    OCCUPIED = 2'd2,
    LEAVING  = 2'd3
  } slot_state_t;

  localparam int unsigned DEF_NUM_SLOTS      = 5;
  localparam int unsigned DEF_CLK_DIV        = 1000000;
  localparam int unsigned DEF_DEBOUNCE_TICKS = 8;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/slot_debounce.sv
// Single-slot synchroniser and debounce FSM.
// Ports:
//   clock         system clock
//   reset         synchronous active-high reset
//   sample_tick   debounce evaluation strobe from the shared divider
//   sensor_raw    asynchronous raw presence sensor, 1 = car detected
//   occupied      debounced occupancy (1 in OCCUPIED and LEAVING)
//   arrive_pulse  one-clock pulse when the slot becomes occupied
//   depart_pulse  one-clock pulse when the slot becomes free
module slot_debounce
  import parking_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
  input  logic clock,
  input  logic reset,
  input  logic sample_tick,
  input  logic sensor_raw,
  output logic occupied,
  output logic arrive_pulse,
  output logic depart_pulse
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_TICKS + 1);
  // cnt + 1 == DEBOUNCE_TICKS, expressed without widening the counter
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_TICKS - 1);

  logic            r_sync1;
  logic            r_sync2;
  slot_state_t     r_state;
  logic [CntW-1:0] r_cnt;
  logic            r_arrive;
  logic            r_depart;

  slot_state_t     w_state_d;
  logic [CntW-1:0] w_cnt_d;
  logic            w_arrive_d;
  logic            w_depart_d;

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_arrive_d = 1'b0;
    w_depart_d = 1'b0;
    if (sample_tick) begin
      unique case (r_state)
        FREE: begin
          if (r_sync2) begin
            if (DEBOUNCE_TICKS == 1) begin
              w_state_d  = OCCUPIED;
              w_cnt_d    = '0;
              w_arrive_d = 1'b1;
            end else begin
              w_state_d = ARRIVING;
              w_cnt_d   = CntW'(1);
            end
          end
        end
        ARRIVING: begin
          if (!r_sync2) begin
            w_state_d = FREE;
            w_cnt_d   = '0;
          end else if (r_cnt == CntLast) begin
            w_state_d  = OCCUPIED;
            w_cnt_d    = '0;
            w_arrive_d = 1'b1;
          end else begin
            w_cnt_d = r_cnt + CntW'(1);
          end
        end
        OCCUPIED: begin
          if (!r_sync2) begin
            if (DEBOUNCE_TICKS == 1) begin
              w_state_d  = FREE;
              w_cnt_d    = '0;
              w_depart_d = 1'b1;
            end else begin
              w_state_d = LEAVING;
              w_cnt_d   = CntW'(1);
            end
          end
        end
        LEAVING: begin
          if (r_sync2) begin
            w_state_d = OCCUPIED;
            w_cnt_d   = '0;
          end else if (r_cnt == CntLast) begin
            w_state_d  = FREE;
            w_cnt_d    = '0;
            w_depart_d = 1'b1;
          end else begin
            w_cnt_d = r_cnt + CntW'(1);
          end
        end
        default: begin
          w_state_d = FREE;
          w_cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_state  <= FREE;
      r_cnt    <= '0;
      r_arrive <= 1'b0;
      r_depart <= 1'b0;
    end else begin
      r_sync1  <= sensor_raw;
      r_sync2  <= r_sync1;
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_arrive <= w_arrive_d;
      r_depart <= w_depart_d;
    end
  end

  assign occupied     = (r_state == OCCUPIED) || (r_state == LEAVING);
  assign arrive_pulse = r_arrive;
  assign depart_pulse = r_depart;

endmodule

// File: rtl/parking_slot_sensor.sv
// Parking lot sensor front-end: synchronises and debounces per-slot presence
// sensors and produces the clean occupancy vector for the display block.
// Optional build macro: PARK_EVENT_COUNT_EN adds the total_arrivals counter.
// Ports:
//   clock           system clock
//   reset           synchronous active-high reset
//   sensor_raw      raw asynchronous presence sensors, 1 = car detected
//   occupied        debounced occupancy vector, 1 = slot taken
//   free_count      number of free slots, registered from occupied
//   lot_full        high when every slot is occupied, registered from occupied
//   arrive_pulse    per-slot one-clock pulse on becoming occupied
//   depart_pulse    per-slot one-clock pulse on becoming free
//   sample_tick     one-clock strobe every CLK_DIV cycles
//   total_arrivals  (PARK_EVENT_COUNT_EN only) saturating count of arrivals
module parking_slot_sensor
  import parking_pkg::*;
#(
  parameter int unsigned NUM_SLOTS      = DEF_NUM_SLOTS,
  parameter int unsigned CLK_DIV        = DEF_CLK_DIV,
  parameter int unsigned DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_SLOTS-1:0]           sensor_raw,
  output logic [NUM_SLOTS-1:0]           occupied,
  output logic [$clog2(NUM_SLOTS+1)-1:0] free_count,
  output logic                           lot_full,
  output logic [NUM_SLOTS-1:0]           arrive_pulse,
  output logic [NUM_SLOTS-1:0]           depart_pulse,
  output logic                           sample_tick
`ifdef PARK_EVENT_COUNT_EN
  ,
  output logic [15:0]                    total_arrivals
`endif
);

  localparam int unsigned CntW = $clog2(NUM_SLOTS + 1);
  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Sample-tick divider
  logic [DivW-1:0] r_div;
  logic            w_tick;

  assign w_tick      = (r_div == DivW'(CLK_DIV - 1));
  assign sample_tick = w_tick;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DivW'(1);
    end
  end

  // Per-slot debouncers
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    slot_debounce #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_slot (
      .clock       (clock),
      .reset       (reset),
      .sample_tick (w_tick),
      .sensor_raw  (sensor_raw[g]),
      .occupied    (occupied[g]),
      .arrive_pulse(arrive_pulse[g]),
      .depart_pulse(depart_pulse[g])
    );
  end

  // Free count is a popcount, so it cannot drift or wrap
  int unsigned     w_occ_cnt;
  logic [CntW-1:0] w_free_next;
  logic [CntW-1:0] r_free_count;
  logic            r_lot_full;

  assign w_occ_cnt   = popcount(32'(occupied));
  assign w_free_next = CntW'(NUM_SLOTS - w_occ_cnt);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_free_count <= CntW'(NUM_SLOTS);
      r_lot_full   <= 1'b0;
    end else begin
      r_free_count <= w_free_next;
      r_lot_full   <= (w_free_next == '0);
    end
  end

  assign free_count = r_free_count;
  assign lot_full   = r_lot_full;

`ifdef PARK_EVENT_COUNT_EN
  logic [15:0] r_total_arrivals;
  logic [16:0] w_arr_sum;

  assign w_arr_sum = {1'b0, r_total_arrivals} + 17'(popcount(32'(arrive_pulse)));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_total_arrivals <= '0;
    end else if (w_arr_sum[16]) begin
      r_total_arrivals <= 16'hFFFF;
    end else begin
      r_total_arrivals <= w_arr_sum[15:0];
    end
  end

  assign total_arrivals = r_total_arrivals;
`endif

endmodule

// File: doc/parking_slot_sensor.md
Name: parking_slot_sensor

Overview:
- Front-end stage directly upstream of the lot display/indicator block.
- Takes raw, noisy, asynchronous per-slot presence sensors and synchronises and debounces them.
- Produces the clean per-slot occupancy vector that the display block consumes as its slot inputs, plus free-slot count, full flag and arrival/departure event pulses.
- Contains its own sample-tick divider, so debounce timing is independent of the display refresh clock.

Parameters:
- NUM_SLOTS, 5: number of parking slots/sensors.
- CLK_DIV, 1000000: clock cycles per sample tick (100 Hz at 100 MHz).
- DEBOUNCE_TICKS, 8: consecutive agreeing samples needed to change a slot's state.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- sensor_raw  input  NUM_SLOTS  raw presence sensors, 1 = car detected, asynchronous.
- occupied  output  NUM_SLOTS  debounced occupancy, 1 = slot taken; feeds the display block's slot inputs.
- free_count  output  $clog2(NUM_SLOTS+1)  number of zero bits in occupied.
- lot_full  output  1  high when every slot is occupied.
- arrive_pulse  output  NUM_SLOTS  one-clock pulse when a slot becomes occupied.
- depart_pulse  output  NUM_SLOTS  one-clock pulse when a slot becomes free.
- sample_tick  output  1  one-clock strobe every CLK_DIV cycles; for bench observation.

Behaviour:
- Clock and reset: one clock, `clock`; reset is synchronous and active-high (`reset`). Every register clears on the first clock edge with reset high.
- Reset values: occupied=0, free_count=NUM_SLOTS, lot_full=0, all pulses=0, sample_tick=0, divider=0, all slots in FREE with counter=0.
- Reset mid-operation discards any debounce in progress; no pulse is emitted.
- Synchroniser: each sensor_raw bit passes through 2 flops (sens_s); all FSMs use sens_s only.
- Divider:
  - counts 0..CLK_DIV-1.
  - sample_tick is high for the one cycle in which the counter equals CLK_DIV-1; the counter then wraps to 0.
  - First tick occurs CLK_DIV cycles after reset deassertion.
- Per-slot FSM (state + counter, width $clog2(DEBOUNCE_TICKS+1)):
  - Evaluated only on sample_tick cycles; otherwise holds.
  - FREE: sens_s=1 -> ARRIVING, cnt=1. If DEBOUNCE_TICKS=1, go directly to OCCUPIED (see below).
  - ARRIVING:
    - sens_s=0 -> FREE, cnt=0 (glitch rejected).
    - sens_s=1 and cnt+1==DEBOUNCE_TICKS -> OCCUPIED, cnt=0, occupied[i]<=1, arrive_pulse[i]<=1.
    - otherwise cnt++.
  - OCCUPIED: sens_s=0 -> LEAVING, cnt=1.
  - LEAVING:
    - sens_s=1 -> OCCUPIED, cnt=0.
    - sens_s=0 and cnt+1==DEBOUNCE_TICKS -> FREE, occupied[i]<=0, depart_pulse[i]<=1.
    - otherwise cnt++.
- occupied[i] is 1 exactly in OCCUPIED and LEAVING.
- Pulses are high for exactly one clock: the cycle after the qualifying tick edge.
- Latency: a clean sensor edge reaches `occupied` 2 sync cycles + DEBOUNCE_TICKS ticks later, +1 register cycle.
- Count and full flag:
  - free_count and lot_full are registered from the occupied vector, so they lag occupied by 1 cycle.
  - lot_full = (free_count_next == 0).
- Simultaneous events: slots are fully independent. Several arrive/depart pulses may assert in the same cycle; free_count reflects the net change in one step.
- Boundaries:
  - free_count never underflows or exceeds NUM_SLOTS (it is a popcount, not an up/down counter).
  - Sensor toggling every tick never completes a transition.

Optional Feature:
- Macro: PARK_EVENT_COUNT_EN.
- Defined:
  - Adds output total_arrivals [15:0], a count of arrive_pulse events.
  - Increments by popcount(arrive_pulse) per cycle and saturates at 16'hFFFF.
  - Reset value 0.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- Package parking_pkg:
  - slot_state_t enum (FREE, ARRIVING, OCCUPIED, LEAVING), 2-bit encoding 0..3.
  - default constants for NUM_SLOTS, CLK_DIV and DEBOUNCE_TICKS.
  - popcount function.
- Sub-module slot_debounce: one instance per slot via generate. Holds the synchroniser, FSM, counter and pulse outputs, and takes sample_tick as input.
- Top level: divider, generate loop, count/full logic, optional event counter.

Test Plan (bench uses CLK_DIV=4, DEBOUNCE_TICKS=3, NUM_SLOTS=5):
- Reset: hold reset 3 cycles, sensor_raw=5'b11111 -> occupied=0, free_count=5, lot_full=0. First sample_tick occurs 4 cycles after release.
- Clean arrival: sensor_raw[2]=1 held -> occupied=5'b00100 after the 3rd qualifying tick. arrive_pulse[2] is high for 1 cycle; free_count=4 on the next cycle.
- Glitch reject: sensor_raw[0] high for 2 ticks, then low -> occupied stays 0 and no pulse.
- Fill lot: all sensors high -> occupied=5'b11111, five simultaneous arrive pulses, free_count=0, lot_full=1. Drop sensor_raw[4] for 3 ticks -> depart_pulse[4], free_count=1, lot_full=0.
- Reset mid-debounce: assert reset while slot 1 is in ARRIVING with cnt=2 -> after release, slot 1 restarts and needs 3 fresh ticks. No arrive pulse is emitted at reset.
- With PARK_EVENT_COUNT_EN: 3 arrive events, one of them with 2 slots simultaneous (4 arrivals total) -> total_arrivals=4. Preload near 16'hFFFF -> holds at 16'hFFFF.
